// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand width and the iteration counter width rule.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int SEQ_DIV_N_DEFAULT = 4;

    // Counter must hold the value N, so it needs clog2(N+1) bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_datapath.sv
// Shift/subtract datapath for the restoring divider: partial remainder R
// (N+1 bits), quotient/dividend shift register Q, divisor D and the
// iteration counter. Controlled by load, clear and step from the FSM.
module div_datapath
    import seq_divider_pkg::*;
#(
    parameter int N  = SEQ_DIV_N_DEFAULT,
    parameter int CW = cnt_width(SEQ_DIV_N_DEFAULT)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic         i_step,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_count_last
);

    logic [N:0]    r_rem;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_d;
    logic [CW-1:0] r_cnt;

    logic [N:0]    w_shift;
    logic [N:0]    w_trial;
    logic          w_fits;

    // Shift {R,Q} left by one and try subtracting the divisor.
    assign w_shift = {r_rem[N-1:0], r_q[N-1]};
    assign w_trial = w_shift - {1'b0, r_d};
    // A bit carried out of R would make the shifted value exceed any D.
    assign w_fits  = r_rem[N] | ~w_trial[N];

    // Operand load, restoring step and counter update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_q   <= i_dividend;
            r_d   <= i_divisor;
            r_cnt <= CW'(N);
        end else if (i_step) begin
            r_q   <= {r_q[N-2:0], w_fits};
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Partial remainder: cleared at acceptance, restored or replaced each step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem <= '0;
        end else if (i_clear) begin
            r_rem <= '0;
        end else if (i_step) begin
            r_rem <= w_fits ? w_trial : w_shift;
        end
    end

    assign o_quotient   = r_q;
    assign o_remainder  = r_rem[N-1:0];
    assign o_count_last = (r_cnt == CW'(1));

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider top: start/done handshake FSM driving the
// div_datapath shift/subtract unit, one quotient bit per clock.
// Optional build macro SEQ_DIV_DIVZ_FLAG_EN adds the div_by_zero output.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = SEQ_DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done
`ifdef SEQ_DIV_DIVZ_FLAG_EN
    ,
    output logic         div_by_zero
`endif
);

    localparam int CW = cnt_width(N);

    div_state_e r_state;
    logic       r_busy;
    logic       r_done;
    logic       w_load;
    logic       w_step;
    logic       w_count_last;

    assign w_load = (r_state == IDLE) && start;
    assign w_step = (r_state == RUN);

    // Control FSM with registered busy/done; busy drops one cycle after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= start;
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_count_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_DIV_DIVZ_FLAG_EN
    logic r_divz;

    // Divide-by-zero flag captured with the operands at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divz <= 1'b0;
        end else if (w_load) begin
            r_divz <= (divisor == '0);
        end
    end

    assign div_by_zero = r_divz;
`endif

    div_datapath #(
        .N  (N),
        .CW (CW)
    ) u_datapath (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load       (w_load),
        .i_clear      (w_load),
        .i_step       (w_step),
        .i_dividend   (dividend),
        .i_divisor    (divisor),
        .o_quotient   (quotient),
        .o_remainder  (remainder),
        .o_count_last (w_count_last)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4) against an arithmetic model.
module tb_seq_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
`ifdef SEQ_DIV_DIVZ_FLAG_EN
    logic         div_by_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] sa, sb;
    int           pulses;
    logic [N-1:0] cq, cr;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
`ifdef SEQ_DIV_DIVZ_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_q(input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == 0) ? {N{1'b1}} : N'(a / b);
    endfunction

    function automatic logic [N-1:0] model_r(input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == 0) ? a : N'(a % b);
    endfunction

    // One isolated division with start pulsed for one cycle.
    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b);
        int k;
        bit seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        check("busy_after_start", 32'(busy), 1);
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (done) seen = 1;
        end
        check("done_seen", 32'(seen), 1);
        check("latency", 32'(k), 5);
        check("quotient", 32'(quotient), 32'(model_q(a, b)));
        check("remainder", 32'(remainder), 32'(model_r(a, b)));
        check("busy_at_done", 32'(busy), 1);
`ifdef SEQ_DIV_DIVZ_FLAG_EN
        check("div_by_zero", 32'(div_by_zero), 32'(b == 0));
`endif
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 0);
        check("busy_fall", 32'(busy), 0);
        check("quotient_hold", 32'(quotient), 32'(model_q(a, b)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
`ifdef SEQ_DIV_DIVZ_FLAG_EN
        check("rst_divz", 32'(div_by_zero), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_div(4'd13, 4'd3);
        do_div(4'd15, 4'd1);
        do_div(4'd2, 4'd7);
        do_div(4'd9, 4'd0);
        do_div(4'd8, 4'd2);

        // Start during RUN must be ignored
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0;
        cq = '0;
        cr = '0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                cq = quotient;
                cr = remainder;
            end
        end
        check("ignored_start_pulses", 32'(pulses), 1);
        check("ignored_start_q", 32'(cq), 4);
        check("ignored_start_r", 32'(cr), 1);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        dividend = 4'd12;
        divisor  = 4'd0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_q", 32'(quotient), 0);
        check("async_rst_r", 32'(remainder), 0);
`ifdef SEQ_DIV_DIVZ_FLAG_EN
        check("async_rst_divz", 32'(div_by_zero), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("no_done_after_abort", 32'(pulses), 0);
        do_div(4'd11, 4'd4);

        // Randomized operands
        repeat (20) do_div(N'($urandom), N'($urandom));

        // Exhaustive sweep with start held high (back-to-back)
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int  k;
            bit  seen;
            sa = N'(i >> 4);
            sb = N'(i);
            dividend = sa;
            divisor  = sb;
            k = 0;
            seen = 0;
            while (!seen && k < 20) begin
                @(posedge clk);
                #1;
                k++;
                if (done) seen = 1;
            end
            check("sweep_period", 32'(k), 6);
            check("sweep_q", 32'(quotient), 32'(model_q(sa, sb)));
            check("sweep_r", 32'(remainder), 32'(model_r(sa, sb)));
            check("sweep_identity", 32'(N'(32'(quotient) * 32'(sb) + 32'(remainder))), 32'(sa));
            if (sb != 0) check("sweep_r_lt_d", 32'(remainder < sb), 1);
`ifdef SEQ_DIV_DIVZ_FLAG_EN
            check("sweep_divz", 32'(div_by_zero), 32'(sb == 0));
`endif
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("sweep_end_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring divider, the inverse companion of the 4-bit shift-add multiplier. It computes an unsigned quotient and remainder, one quotient bit per clock. The block is split into an FSM control path and a shift/subtract datapath, and sits beside the multiplier in the arithmetic subsystem. Its start/done handshake matches the multiplier's, so one sequencer can drive both.

Parameters:
N, 4, operand width in bits for dividend, divisor, quotient and remainder (N >= 2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
dividend  input  N  unsigned dividend; sampled on the edge that accepts start
divisor  input  N  unsigned divisor; sampled on the edge that accepts start
quotient  output  N  unsigned quotient; valid from done until the next accepted start
remainder  output  N  unsigned remainder; valid from done until the next accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
div_by_zero  output  1  present only with SEQ_DIV_DIVZ_FLAG_EN

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, counter=0.
- Reset mid-operation: the FSM aborts to IDLE immediately. Outputs go to their reset values. There is no done pulse for the aborted operation.
- States:
  - IDLE: if start=1, latch dividend into Q, divisor into D, clear R (N+1 bits), set counter=N, and go to RUN. Otherwise stay in IDLE.
  - RUN: each cycle performs one restoring step, then decrements counter. When counter reaches 1 on this edge, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Restoring step:
  - Shift {R,Q} left by 1 and form trial = R_shifted - {1'b0,D}.
  - If the trial MSB is 0: R = trial and Q[0] = 1.
  - Otherwise: keep R_shifted and set Q[0] = 0.
- Outputs: quotient = Q and remainder = R[N-1:0]. Both are registered. They change during RUN and must be sampled only at or after done.
- Latency: start is accepted at edge 0. Iterations run at edges 1..N. done is high in the cycle after edge N+1, so the operation is N+2 cycles from start edge to done inclusive. For N=4: start sampled at edge 0, done high between edges 5 and 6.
- start in RUN or DONE is ignored, with no queueing. start held high continuously re-triggers in the first IDLE cycle after DONE.
- Inputs changing after acceptance have no effect.
- Divide by zero: no special path. The natural restoring result is quotient = all ones and remainder = dividend. Latency is unchanged.
- Width rule: remainder < divisor whenever divisor != 0, and dividend = quotient*divisor + remainder exactly in N-bit unsigned arithmetic.

Optional Feature:
- SEQ_DIV_DIVZ_FLAG_EN defined:
  - Adds the div_by_zero output, registered at start acceptance as (divisor == 0).
  - It holds until the next accepted start or rst.
  - Quotient and remainder values are unchanged (all ones / dividend).
- Not defined: the port is absent, no flag logic is built, and divide by zero yields the same natural result silently.

Decomposition:
- Shared package:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter width constant, equal to clog2(N+1).
- Sub-module div_datapath holds the R, Q and D registers, the subtractor/restore mux and the counter. It takes load, step and clear controls and returns count_last.
- The FSM stays in seq_divider, mirroring the multiplier's control/datapath split.

Test Plan:
- N=4, dividend=13, divisor=3 -> done exactly 5 cycles after the start edge, quotient=4, remainder=1, busy falls the cycle after done.
- dividend=15, divisor=1 -> quotient=15, remainder=0. dividend=2, divisor=7 -> quotient=0, remainder=2.
- dividend=9, divisor=0 -> quotient=15, remainder=9, normal latency. With SEQ_DIV_DIVZ_FLAG_EN, div_by_zero=1; a following 8/2 clears it (quotient=4, remainder=0).
- start 13/3 and pulse start with 6/2 two cycles later -> second request ignored, result quotient=4, remainder=1. Exactly one done pulse.
- Assert rst asynchronously mid-RUN -> busy, done, quotient and remainder read 0 without waiting for clk, no done pulse. A new start after release gives a correct result.
- Exhaustive sweep of all 256 operand pairs with start held high -> back-to-back operations. Every done satisfies dividend = quotient*divisor + remainder, and remainder < divisor for divisor != 0.
